// File: rtl/sys_defs.sv
// Shared store-queue types: entry payload, data width and queue depth.
// Pure declarations; no latency and no flow control.
package sys_defs;
  localparam int XLEN = 32;
  localparam int LSQ  = 8;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [3:0]      usebytes;
  } SQ_ENTRY_PACKET;
endpackage

// File: rtl/sq_fwd_search.sv
// Youngest-match search over [head, ld_age) for store-to-load forwarding; combinational, 0 cycles.
// No backpressure: a stall result tells the load to retry until the store is complete.
module sq_fwd_search
  import sys_defs::*;
#(
  parameter int SQ_IDX_W = 3
) (
  input  SQ_ENTRY_PACKET [2**SQ_IDX_W-1:0] ent,
  input  logic [2**SQ_IDX_W-1:0]           rdy,
  input  logic [SQ_IDX_W:0]                head,
  input  logic                             ld_valid,
  input  logic [XLEN-1:0]                  ld_addr,
  input  logic [SQ_IDX_W:0]                ld_age,
  output logic                             fwd_hit,
  output logic                             fwd_stall,
  output logic [XLEN-1:0]                  fwd_data
);
  localparam int DEPTH = 2**SQ_IDX_W;

  logic [SQ_IDX_W:0]   span;
  logic [SQ_IDX_W-1:0] m_idx;
  logic                found;

  assign span = ld_age - head;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [SQ_IDX_W:0]   off;
    logic [SQ_IDX_W-1:0] idx;
    found = 1'b0;
    m_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = i[SQ_IDX_W:0];
      idx = head[SQ_IDX_W-1:0] + i[SQ_IDX_W-1:0];
      if (ld_valid && (off < span) && (ent[idx].addr[XLEN-1:2] == ld_addr[XLEN-1:2])) begin
        found = 1'b1;
        m_idx = idx;
      end
    end
  end

  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    if (found) begin
      if (rdy[m_idx] && (ent[m_idx].usebytes == 4'b1111)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent[m_idx].data;
      end else begin
        fwd_stall = 1'b1;
      end
    end
  end
endmodule

// File: rtl/store_queue.sv
// Circular store queue: in-order alloc, ALU fill, ROB commit, one-at-a-time D-cache drain; flags are 0-cycle from registered state.
// Drops dispatch when full, holds dc_* stable until dc_ack; SQ_FWD_EN adds load forwarding ports.
module store_queue
  import sys_defs::*;
#(
  parameter int SQ_IDX_W = $clog2(LSQ)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                dispatch_req,
  output logic [SQ_IDX_W-1:0] sq_tail,
  output logic                sq_full,
  output logic                sq_empty,
  input  logic                if_store,
  input  logic [SQ_IDX_W-1:0] sq_idx,
  input  SQ_ENTRY_PACKET      store_pckt,
  input  logic                retire_req,
  output logic                retire_ok,
  input  logic                flush,
  output logic                dc_req,
  output logic [XLEN-1:0]     dc_addr,
  output logic [XLEN-1:0]     dc_data,
  output logic [3:0]          dc_usebytes,
  input  logic                dc_ack
`ifdef SQ_FWD_EN
  ,
  input  logic                ld_valid,
  input  logic [XLEN-1:0]     ld_addr,
  input  logic [SQ_IDX_W:0]   ld_age,
  output logic                fwd_hit,
  output logic                fwd_stall,
  output logic [XLEN-1:0]     fwd_data
`endif
);
  localparam int DEPTH = 2**SQ_IDX_W;
  typedef logic [SQ_IDX_W:0] ptr_t;

  ptr_t head, cmt, tail, cmt_nxt, fill_span, fill_off, sq_span;
  SQ_ENTRY_PACKET [DEPTH-1:0] ent;
  logic [DEPTH-1:0] rdy, rdy_nxt, squash;
  logic do_retire, do_drain, do_alloc, do_fill;
  logic [SQ_IDX_W-1:0] head_idx;

  assign head_idx  = head[SQ_IDX_W-1:0];
  assign sq_tail   = tail[SQ_IDX_W-1:0];
  assign sq_full   = (tail - head) == ptr_t'(DEPTH);
  assign sq_empty  = (tail == head);
  assign retire_ok = (cmt != tail) && rdy[cmt[SQ_IDX_W-1:0]];
  assign do_retire = retire_req && retire_ok;
  assign cmt_nxt   = cmt + ptr_t'(do_retire);
  assign dc_req    = (head != cmt);
  assign do_drain  = dc_ack && dc_req;
  assign do_alloc  = dispatch_req && !sq_full && !flush;

  // A flush in the same cycle narrows the fill window to what survives it.
  assign fill_span = (flush ? cmt_nxt : tail) - cmt;
  assign fill_off  = {1'b0, sq_idx - cmt[SQ_IDX_W-1:0]};
  assign do_fill   = if_store && (fill_off < fill_span);
  assign sq_span   = tail - cmt_nxt;

  assign dc_addr     = dc_req ? ent[head_idx].addr     : '0;
  assign dc_data     = dc_req ? ent[head_idx].data     : '0;
  assign dc_usebytes = dc_req ? ent[head_idx].usebytes : '0;

  always_comb begin
    logic [SQ_IDX_W-1:0] off;
    squash = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off       = i[SQ_IDX_W-1:0] - cmt_nxt[SQ_IDX_W-1:0];
      squash[i] = flush && ({1'b0, off} < sq_span);
    end
  end

  always_comb begin
    rdy_nxt = rdy;
    if (do_fill) rdy_nxt[sq_idx] = 1'b1;
    if (do_drain) rdy_nxt[head_idx] = 1'b0;
    rdy_nxt = rdy_nxt & ~squash;
    if (do_alloc) rdy_nxt[tail[SQ_IDX_W-1:0]] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
      rdy  <= '0;
    end else begin
      head <= head + ptr_t'(do_drain);
      cmt  <= cmt_nxt;
      tail <= flush ? cmt_nxt : tail + ptr_t'(do_alloc);
      rdy  <= rdy_nxt;
    end
  end

  // Payload is only observed through ready/dc_req qualification, so it needs no reset.
  always_ff @(posedge clock) begin
    if (do_fill) ent[sq_idx] <= store_pckt;
  end

`ifdef SQ_FWD_EN
  sq_fwd_search #(.SQ_IDX_W(SQ_IDX_W)) u_fwd (
    .ent      (ent),
    .rdy      (rdy),
    .head     (head),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_age   (ld_age),
    .fwd_hit  (fwd_hit),
    .fwd_stall(fwd_stall),
    .fwd_data (fwd_data)
  );
`endif
endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Circular store queue that sits at the receiving end of the ALU store interface (if_store / store_pckt / sq_idx).
- Allocates entries in program order at dispatch and hands the tail index to the RS/ALU.
- Captures address/data/byte-enables when the ALU executes a store, marks entries committed on ROB retire, and drains committed stores to the D-cache one at a time over a req/ack handshake.
- Squashes uncommitted entries on a pipeline flush.

Parameters:
- SQ_IDX_W, 3, index width; depth = 2**SQ_IDX_W entries (matches `LSQ).
- XLEN, 32, address/data width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- dispatch_req  in  1  allocate one entry this cycle
- sq_tail  out  SQ_IDX_W  index the next allocation receives (carried to ALU as sq_idx)
- sq_full  out  1  no free entry
- sq_empty  out  1  no allocated entries
- if_store  in  1  ALU store result valid
- sq_idx  in  SQ_IDX_W  entry written by ALU
- store_pckt  in  SQ_ENTRY_PACKET  addr[XLEN], data[XLEN], usebytes[4]
- retire_req  in  1  ROB commits oldest uncommitted store
- retire_ok  out  1  combinational: commit entry allocated and ready
- flush  in  1  squash all uncommitted entries
- dc_req  out  1  drain request
- dc_addr  out  XLEN  head address
- dc_data  out  XLEN  head data
- dc_usebytes  out  4  head byte enables
- dc_ack  in  1  D-cache accepted head store

Behaviour:
- State: per-entry {addr, data, usebytes, ready}.
- Pointers: head (oldest, drain), cmt (oldest uncommitted), tail. Each pointer carries SQ_IDX_W+1 bits; the extra bit is the wrap bit.
- Occupancy: count = tail-head; full when count == 2**SQ_IDX_W; empty when tail == head.
- Reset (reset low, async): all pointers 0, all ready bits 0. Outputs: sq_tail=0, sq_full=0, sq_empty=1, retire_ok=0, dc_req=0, dc_addr/data/usebytes=0.
- Allocation: dispatch_req && !sq_full → entry[tail].ready<=0, tail++ at the clock edge. sq_tail and sq_full reflect the registered state, so full is not relieved by a same-cycle drain. dispatch_req while full is dropped.
- Fill: if_store with sq_idx in [cmt, tail) → addr/data/usebytes written and ready<=1 at the next edge. Fill outside that range is ignored; the bench flags it as an error.
- Retire:
  - retire_ok = (cmt != tail) && entry[cmt].ready.
  - retire_req && retire_ok → cmt++.
  - retire_req && !retire_ok → no effect; ROB must retry.
- Drain:
  - dc_req = (head != cmt). dc_addr/data/usebytes are driven combinationally from entry[head].
  - Outputs are held stable until dc_ack.
  - dc_ack && dc_req → head++, entry ready<=0. dc_ack without dc_req is ignored.
  - Zero-latency back-to-back drain on consecutive acks.
- Flush: tail <= cmt (post-retire value); uncommitted entries lose ready. Committed entries keep draining.
- Simultaneous events in one cycle:
  - flush beats dispatch_req; allocation is dropped.
  - retire beats flush; the retiring entry survives.
  - A fill to a squashed index is ignored.
  - Alloc, fill, retire and drain on distinct entries all proceed in one cycle.
- Wrap-around: indices are taken modulo depth; wrap bits disambiguate full vs empty.
- Reset asserted mid-operation: all state is discarded immediately, including a pending dc_req. The D-cache must treat reset as cancelling an unacked request.

Optional Feature:
- Macro: SQ_FWD_EN.
- With it defined, extra ports are present:
  - ld_valid in 1, ld_addr in XLEN, ld_age in SQ_IDX_W+1 (sq tail captured at load dispatch)
  - fwd_hit out 1, fwd_stall out 1, fwd_data out XLEN
- Search: the youngest entry in [head, ld_age) whose word address (addr[XLEN-1:2]) matches ld_addr.
- Result, combinational, same cycle:
  - Match is ready with usebytes 1111 → fwd_hit=1 and fwd_data=data.
  - Match is unready or partial → fwd_stall=1.
  - No match → both 0.
- Without the macro the ports and logic are absent and loads never consult the queue.

Decomposition:
- Shared package (sys_defs): SQ_ENTRY_PACKET typedef, `LSQ depth constant, XLEN.
- One natural sub-module: sq_fwd_search, the age-masked youngest-match priority search. It is instantiated only under SQ_FWD_EN.

Test Plan:
- Reset then 8 dispatch_req → sq_tail counts 0..7; sq_full=1 after the 8th. A 9th request is dropped and tail stays at wrap value 8.
- Alloc idx0, fill {addr 0x1000_0000, data 0xDEADBEEF, usebytes 1111}, retire_req → retire_ok=1, then dc_req=1 with those exact values. dc_ack → sq_empty=1.
- Retire_req on an allocated but unfilled entry → retire_ok=0 and cmt unchanged. Fill next cycle → retire succeeds.
- Alloc 4, fill all, retire 2, flush → tail=cmt=2. Only 2 drains occur; a late fill to idx3 is ignored.
- Run 20 store alloc/fill/retire/drain iterations with dc_ack delayed 3 cycles → in-order drain across wrap, dc_* stable while unacked.
- SQ_FWD_EN: store 0x55AA_1234 @0x200 ready, load 0x200 with ld_age=1 → fwd_hit=1, fwd_data=0x55AA_1234. Same store with usebytes 0011 → fwd_stall=1.
